// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit saturating counter table with combinational lookup,
// plus a one-cycle branch resolve stage that trains the table and tracks mispredict statistics.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_LSB     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [XLEN-1:0]        lookup_pc,
    output logic                   pred_taken,
    input  logic                   valid_i,
    input  logic signed [XLEN-1:0] A,
    input  logic signed [XLEN-1:0] B,
    input  logic [4:0]             BrOp,
    input  logic [XLEN-1:0]        br_pc,
    input  logic                   pred_i,
    output logic                   valid_o,
    output logic                   NextPCSrc,
    output logic                   mispredict,
    output logic [31:0]            br_count,
    output logic [31:0]            miss_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic             valid_q, valid_d;
    logic             taken_q, taken_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      miss_count_q, miss_count_d;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] br_idx;
    logic             is_jump;
    logic             is_cond;
    logic             cond_taken;
    logic             resolved_taken;
    logic             unused_pc_bits;

    assign lookup_idx     = lookup_pc[IDX_LSB +: IDX_W];
    assign br_idx         = br_pc[IDX_LSB +: IDX_W];
    assign unused_pc_bits = ^{lookup_pc, br_pc};

    // The table resets to weakly-not-taken, so bit 1 is already 0; the rst gate
    // keeps the prediction low even while the asynchronous clear is propagating.
    assign pred_taken = bht_q[lookup_idx][1] & ~rst;

    always_comb begin
        is_jump    = BrOp[4];
        is_cond    = ~BrOp[4] & BrOp[3] & (BrOp[2:1] != 2'b01);
        cond_taken = 1'b0;
        case (BrOp[2:0])
            3'b000:  cond_taken = (A == B);
            3'b001:  cond_taken = (A != B);
            3'b100:  cond_taken = (A < B);
            3'b101:  cond_taken = (A >= B);
            3'b110:  cond_taken = ($unsigned(A) < $unsigned(B));
            3'b111:  cond_taken = ($unsigned(A) >= $unsigned(B));
            default: cond_taken = 1'b0;
        endcase
        resolved_taken = is_jump | (is_cond & cond_taken);
    end

    always_comb begin
        bht_d        = bht_q;
        valid_d      = valid_i;
        taken_d      = valid_i & resolved_taken;
        mispredict_d = valid_i & (resolved_taken ^ pred_i);
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (valid_i && is_cond) begin
            br_count_d = br_count_q + 32'd1;
            if (resolved_taken != pred_i) begin
                miss_count_d = miss_count_q + 32'd1;
            end
            if (resolved_taken) begin
                if (bht_q[br_idx] != 2'b11) bht_d[br_idx] = bht_q[br_idx] + 2'd1;
            end else begin
                if (bht_q[br_idx] != 2'b00) bht_d[br_idx] = bht_q[br_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bht_q        <= '{default: 2'b01};
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            bht_q        <= bht_d;
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign valid_o    = valid_q;
    assign NextPCSrc  = taken_q;
    assign mispredict = mispredict_q;
    assign br_count   = br_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed by random
// traffic, all compared against an array-based reference predictor.
module tb_branch_predict_unit;

    localparam int XLEN = 32;
    localparam int N    = 16;
    localparam int LSB  = 2;

    logic              clk;
    logic              rst;
    logic [XLEN-1:0]   lookup_pc;
    logic              pred_taken;
    logic              valid_i;
    logic [XLEN-1:0]   A;
    logic [XLEN-1:0]   B;
    logic [4:0]        BrOp;
    logic [XLEN-1:0]   br_pc;
    logic              pred_i;
    logic              valid_o;
    logic              NextPCSrc;
    logic              mispredict;
    logic [31:0]       br_count;
    logic [31:0]       miss_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ctr [N];
    bit [31:0]   m_br;
    bit [31:0]   m_miss;

    branch_predict_unit #(
        .XLEN(XLEN),
        .BHT_ENTRIES(N),
        .IDX_LSB(LSB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lookup_pc(lookup_pc),
        .pred_taken(pred_taken),
        .valid_i(valid_i),
        .A(A),
        .B(B),
        .BrOp(BrOp),
        .br_pc(br_pc),
        .pred_i(pred_i),
        .valid_o(valid_o),
        .NextPCSrc(NextPCSrc),
        .mispredict(mispredict),
        .br_count(br_count),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc >> LSB) % N);
    endfunction

    function automatic bit model_is_cond(input bit [4:0] op);
        return !op[4] && op[3] && (op[2:0] != 3'd2) && (op[2:0] != 3'd3);
    endfunction

    function automatic bit model_taken(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (op[4]) return 1'b1;
        if (!model_is_cond(op)) return 1'b0;
        case (op[2:0])
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            default: return ua >= ub;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) ctr[i] = 1;
        m_br   = 0;
        m_miss = 0;
    endtask

    // Drives one request at posedge+1, checks the lookup before the edge (old table
    // contents), then checks the registered result after the edge.
    task automatic cycle(input bit v, input bit [4:0] op, input bit [31:0] a, input bit [31:0] b,
                         input bit [31:0] bpc, input bit p, input bit [31:0] lpc);
        bit t;
        bit c;
        int k;
        valid_i   = v;
        BrOp      = op;
        A         = a;
        B         = b;
        br_pc     = bpc;
        pred_i    = p;
        lookup_pc = lpc;
        #1;
        check("pred_taken", pred_taken, (ctr[idx_of(lpc)] >= 2) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        t = v && model_taken(op, a, b);
        c = v && model_is_cond(op);
        if (c) begin
            k = idx_of(bpc);
            ctr[k] = t ? ((ctr[k] < 3) ? ctr[k] + 1 : 3) : ((ctr[k] > 0) ? ctr[k] - 1 : 0);
            m_br++;
            if (t != p) m_miss++;
        end
        check("valid_o", valid_o, {31'd0, v});
        check("NextPCSrc", NextPCSrc, {31'd0, t});
        check("mispredict", mispredict, {31'd0, v && (t ^ p)});
        check("br_count", br_count, m_br);
        check("miss_count", miss_count, m_miss);
    endtask

    // Asserts reset between edges with a request pending, so that request must vanish.
    task automatic reset_pulse();
        valid_i = 1'b1;
        BrOp    = 5'b01000;
        A       = 32'd9;
        B       = 32'd9;
        br_pc   = 32'h10;
        pred_i  = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_NextPCSrc", NextPCSrc, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_br_count", br_count, 0);
        check("rst_miss_count", miss_count, 0);
        for (int i = 0; i < N; i++) begin
            lookup_pc = ($urandom & 32'hFFFF_FFC3) | (i << LSB);
            #1;
            check("rst_pred_taken", pred_taken, 0);
        end
        @(posedge clk);
        #1;
        check("rst_hold_valid_o", valid_o, 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic random_traffic(input int n);
        bit [4:0]  op;
        bit [31:0] a, b, bpc, lpc;
        for (int i = 0; i < n; i++) begin
            op  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : {2'b01, 3'($urandom)};
            a   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2;
            b   = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4)) - 32'd2);
            bpc = $urandom;
            lpc = ($urandom_range(0, 1) == 0) ? bpc : $urandom;
            cycle($urandom_range(0, 3) != 0, op, a, b, bpc, 1'($urandom), lpc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        valid_i   = 1'b0;
        BrOp      = '0;
        A         = '0;
        B         = '0;
        br_pc     = '0;
        pred_i    = 1'b0;
        lookup_pc = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset_pulse();

        // same-cycle update and lookup at index 7: old value now, new value next cycle
        cycle(1, 5'b01000, 32'd3, 32'd3, 32'h1C, 0, 32'h1C);
        cycle(0, 5'b00000, 0, 0, 0, 0, 32'h1C);

        // BEQ taken at index 4, predicted not taken
        cycle(1, 5'b01000, 32'd5, 32'd5, 32'h10, 0, 32'h10);
        cycle(0, 5'b00000, 0, 0, 0, 0, 32'h10);

        // signed versus unsigned comparisons
        cycle(1, 5'b01100, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 32'h20);
        cycle(1, 5'b01110, 32'hFFFF_FFFF, 32'd1, 32'h20, 1, 32'h20);
        cycle(1, 5'b01111, 32'hFFFF_FFFF, 32'd0, 32'h24, 1, 32'h24);

        // saturation at index 3
        for (int i = 0; i < 4; i++) cycle(1, 5'b01001, 32'd1, 32'd2, 32'h0C, 1, 32'h0C);
        cycle(1, 5'b01001, 32'd7, 32'd7, 32'h0C, 1, 32'h0C);
        cycle(0, 5'b00000, 0, 0, 0, 0, 32'h0C);

        // jump, illegal conditional codes, and non-branch
        cycle(1, 5'b10000, 0, 0, 32'h30, 1, 32'h30);
        cycle(1, 5'b01010, 0, 0, 32'h30, 0, 32'h30);
        cycle(1, 5'b01011, 4, 4, 32'h30, 1, 32'h30);
        cycle(1, 5'b00101, 4, 4, 32'h30, 1, 32'h30);
        cycle(0, 5'b00000, 0, 0, 0, 0, 32'h30);

        random_traffic(300);
        reset_pulse();
        cycle(0, 5'b00000, 0, 0, 0, 0, 32'h10);
        random_traffic(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, meaning number of 2-bit counters; a power of 2, at least 2.
REQ-003 SHALL have parameter IDX_LSB, default 2, meaning lowest PC bit used for the table index.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port lookup_pc, input, XLEN bits: fetch-stage PC to predict.
REQ-007 SHALL have port pred_taken, output, 1 bit: prediction for lookup_pc.
REQ-008 SHALL have port valid_i, input, 1 bit: resolve request this cycle.
REQ-009 SHALL have port A, input, XLEN bits, signed: rs1 value.
REQ-010 SHALL have port B, input, XLEN bits, signed: rs2 value.
REQ-011 SHALL have port BrOp, input, 5 bits: branch op code.
REQ-012 SHALL have port br_pc, input, XLEN bits: PC of the resolving branch.
REQ-013 SHALL have port pred_i, input, 1 bit: prediction made earlier for this branch.
REQ-014 SHALL have port valid_o, output, 1 bit: result valid.
REQ-015 SHALL have port NextPCSrc, output, 1 bit: resolved taken.
REQ-016 SHALL have port mispredict, output, 1 bit: NextPCSrc differs from the registered pred_i.
REQ-017 SHALL have port br_count, output, 32 bits: resolved conditional branches.
REQ-018 SHALL have port miss_count, output, 32 bits: mispredicted conditional branches.

Function
REQ-019 SHALL decode BrOp as follows: BrOp[4]=1 is an unconditional jump, taken.
REQ-020 SHALL treat BrOp[4]=0 with BrOp[3]=1 as conditional, with BrOp[2:0] giving 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
REQ-021 SHALL treat BrOp[2:0] of 010 or 011 under a conditional op as not taken and non-conditional, with no update and no count.
REQ-022 SHALL treat BrOp[4:3]=00 as not a branch: not taken, no update.
REQ-023 SHALL compute the index as br_pc[IDX_LSB +: log2(BHT_ENTRIES)], and the same slice of lookup_pc for lookup.
REQ-024 SHALL drive pred_taken combinationally from bit 1 of the indexed counter, with 0 lookup latency.
REQ-025 SHALL register valid_o, NextPCSrc and mispredict on the clk edge at which valid_i=1 is sampled, giving 1-cycle latency.
REQ-026 SHALL clear valid_o, NextPCSrc and mispredict to 0 in cycles with no request.
REQ-027 SHALL update, on a valid conditional branch, the indexed counter at the same edge as the output register: increment saturating at 11 if taken, decrement saturating at 00 if not taken.
REQ-028 SHALL NOT update the table on jumps, non-branches or illegal codes, and their mispredict SHALL equal NextPCSrc XOR pred_i.
REQ-029 SHALL increment br_count by 1 on a valid conditional branch, and SHALL increment miss_count by 1 if that branch also mispredicts; both SHALL wrap modulo 2^32.
REQ-030 SHALL return the pre-update counter value to a lookup made in the same cycle as an update to the same index (read-old); the new value SHALL be visible from the next cycle.
REQ-031 SHALL accept back-to-back requests every cycle with no stall; there is no ready signal.
REQ-032 SHALL make every comparison at full XLEN width, with no truncation.

Reset
REQ-033 SHALL, while rst=1 and asynchronously, set all counters to 01 (weakly not taken) and set valid_o, NextPCSrc, mispredict, br_count and miss_count to 0.
REQ-034 SHALL force pred_taken to 0 during reset and after reset until the first update.
REQ-035 SHALL abandon a request in flight at the reset edge, with no output pulse and no count.

Verification
REQ-036 SHALL cover: rst pulse mid-stream -> all outputs 0 immediately, and pred_taken=0 for every lookup_pc.
REQ-037 SHALL cover: BEQ A=5, B=5, br_pc=0x10, pred_i=0 -> next cycle valid_o=1, NextPCSrc=1, mispredict=1, br_count=1, miss_count=1, and counter[4]=10, so pred_taken=1 for lookup_pc=0x10.
REQ-038 SHALL cover: BLT A=-1, B=1 -> taken; BLTU with the same operands -> not taken; BGEU with A=0xFFFFFFFF, B=0 -> taken.
REQ-039 SHALL cover: four taken BNE at index 3 -> counter saturates at 11; then one not-taken -> 10, with pred_taken still 1.
REQ-040 SHALL cover: an update to index 7 with lookup_pc of index 7 in the same cycle, counter 01 and taken -> pred_taken=0 that cycle and 1 the next.
REQ-041 SHALL cover: jump BrOp=10000 with pred_i=1, then BrOp=01010 -> NextPCSrc=1 then 0, with counts and table unchanged.
